// File: rtl/instr_loader.sv
// Boot-time instruction memory loader: assembles big-endian 32-bit words from a
// byte stream and writes them to consecutive word addresses, holding the CPU in reset.
`timescale 1ns/1ps
module instr_loader #(
  parameter int          ADDR_W    = 10,
  parameter int          DEPTH     = 1024,
  parameter logic [5:0]  FINISH_OP = 6'b111111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] a,
  output logic [31:0]       d,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              cpu_rst,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              r_state, w_next;
  logic [1:0]          r_byte_cnt;
  logic [23:0]         r_shift;
  logic [31:0]         r_word;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_count;
  logic                r_full;
  logic                w_hs, w_finish, w_at_end, w_restart;

  // Derived from the state register, not from in_ready, to keep the comb loop-free.
  assign w_hs      = in_valid && (r_state == S_RECV);
  assign w_finish  = (r_word[31:26] == FINISH_OP);
  assign w_at_end  = (r_addr == LAST_ADDR);
  assign w_restart = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // NOTE: asynchronous reset must appear in the sensitivity list; state uses <= only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    we       = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    cpu_rst  = 1'b1;
    case (r_state)
      S_IDLE: if (start) w_next = S_RECV;
      S_RECV: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_hs && (r_byte_cnt == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        we     = 1'b1;
        busy   = 1'b1;
        w_next = (w_finish || w_at_end) ? S_DONE : S_RECV;
      end
      S_DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
        if (start) w_next = S_RECV;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'd0;
      r_word     <= 32'd0;
      r_addr     <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
    end else begin
      if (w_restart) begin
        r_byte_cnt <= 2'd0;
        r_addr     <= '0;
        r_count    <= '0;
        r_full     <= 1'b0;
      end
      if (w_hs) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        // The completed word lands in its own register so d stays stable until the next word.
        if (r_byte_cnt == 2'd3) r_word  <= {r_shift, in_byte};
        else                    r_shift <= {r_shift[15:0], in_byte};
      end
      if (r_state == S_WRITE) begin
        r_count <= r_count + {{ADDR_W{1'b0}}, 1'b1};
        if (!w_finish) begin
          if (w_at_end) r_full <= 1'b1;
          else          r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign a          = r_addr;
  assign d          = r_word;
  assign full       = r_full;
  assign word_count = r_count;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: a 1024-deep and a 4-deep instance are driven
// with randomized byte streams and compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_instr_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start[2], in_valid[2];
  logic [7:0]  in_byte[2];
  logic        rdy[2], we[2], busy[2], done[2], full[2], cpu_rst[2];
  logic [31:0] d[2];
  logic [9:0]  a0;
  logic [1:0]  a1;
  logic [10:0] wc0;
  logic [2:0]  wc1;

  instr_loader #(.ADDR_W(10), .DEPTH(1024)) u_big (
    .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid[0]), .in_byte(in_byte[0]),
    .in_ready(rdy[0]), .we(we[0]), .a(a0), .d(d[0]), .busy(busy[0]), .done(done[0]),
    .full(full[0]), .cpu_rst(cpu_rst[0]), .word_count(wc0));

  instr_loader #(.ADDR_W(2), .DEPTH(4)) u_small (
    .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid[1]), .in_byte(in_byte[1]),
    .in_ready(rdy[1]), .we(we[1]), .a(a1), .d(d[1]), .busy(busy[1]), .done(done[1]),
    .full(full[1]), .cpu_rst(cpu_rst[1]), .word_count(wc1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, k, act, exp);
    end
  endtask

  function automatic logic [31:0] get_a(input int k);
    return (k == 0) ? 32'(a0) : 32'(a1);
  endfunction

  function automatic logic [31:0] get_wc(input int k);
    return (k == 0) ? 32'(wc0) : 32'(wc1);
  endfunction

  function automatic int depth(input int k);
    return (k == 0) ? 1024 : 4;
  endfunction

  // Behavioural model: a session collects bytes four at a time, writes each word,
  // and stops on a FINISH opcode or on the last address.
  bit          m_active[2], m_done[2], m_full[2], m_wp[2];
  int          m_addr[2], m_count[2], m_nb[2];
  logic [31:0] m_acc[2], m_d[2];

  function automatic bit m_rdy(input int k);
    return m_active[k] && !m_done[k] && !m_wp[k];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_active[k] = 0; m_done[k] = 0; m_full[k] = 0; m_wp[k] = 0;
        m_addr[k] = 0; m_count[k] = 0; m_nb[k] = 0; m_d[k] = 0;
      end else if (m_wp[k]) begin
        m_wp[k] = 0;
        m_count[k]++;
        if (m_d[k][31:26] == 6'h3F) m_done[k] = 1;
        else if (m_addr[k] == depth(k) - 1) begin m_done[k] = 1; m_full[k] = 1; end
        else m_addr[k]++;
      end else if ((!m_active[k] || m_done[k]) && start[k]) begin
        m_active[k] = 1; m_done[k] = 0; m_full[k] = 0;
        m_count[k] = 0; m_addr[k] = 0; m_nb[k] = 0;
      end else if (m_rdy(k) && in_valid[k]) begin
        m_acc[k] = (m_acc[k] << 8) | 32'(in_byte[k]);
        m_nb[k]++;
        if (m_nb[k] == 4) begin m_nb[k] = 0; m_d[k] = m_acc[k]; m_wp[k] = 1; end
      end
    end
  end

  task automatic check_reset(input int k, input string tag);
    check({tag, "_in_ready"}, k, 32'(rdy[k]), 0);
    check({tag, "_we"}, k, 32'(we[k]), 0);
    check({tag, "_busy"}, k, 32'(busy[k]), 0);
    check({tag, "_done"}, k, 32'(done[k]), 0);
    check({tag, "_full"}, k, 32'(full[k]), 0);
    check({tag, "_cpu_rst"}, k, 32'(cpu_rst[k]), 1);
    check({tag, "_a"}, k, get_a(k), 0);
    check({tag, "_d"}, k, d[k], 0);
    check({tag, "_word_count"}, k, get_wc(k), 0);
  endtask

  // Observed write log per instance, with the cycle each write was seen.
  int          log_a0[$], log_a1[$], log_c0[$];
  logic [31:0] log_d0[$], log_d1[$];
  int          cyc = 0;
  int          last_we[2];
  logic        prev_cpu[2] = '{1'b1, 1'b1};

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        check_reset(k, "rst");
      end else begin
        check("in_ready", k, 32'(rdy[k]), 32'(m_rdy(k)));
        check("we", k, 32'(we[k]), 32'(m_wp[k]));
        check("busy", k, 32'(busy[k]), 32'(m_active[k] && !m_done[k]));
        check("done", k, 32'(done[k]), 32'(m_done[k]));
        check("full", k, 32'(full[k]), 32'(m_full[k]));
        check("cpu_rst", k, 32'(cpu_rst[k]), 32'(!m_done[k]));
        check("word_count", k, get_wc(k), 32'(m_count[k]));
        if (m_wp[k] || m_done[k]) begin
          check("a", k, get_a(k), 32'(m_addr[k]));
          check("d", k, d[k], m_d[k]);
        end
        if (prev_cpu[k] && !cpu_rst[k]) check("cpu_rst_fall_latency", k, 32'(cyc - last_we[k]), 1);
        if (we[k]) begin
          last_we[k] = cyc;
          if (k == 0) begin log_a0.push_back(int'(a0)); log_d0.push_back(d[0]); log_c0.push_back(cyc); end
          else        begin log_a1.push_back(int'(a1)); log_d1.push_back(d[1]); end
        end
      end
      prev_cpu[k] = cpu_rst[k];
    end
  end

  task automatic pulse_start(input int k);
    @(negedge clk);
    in_valid[k] = 1'b0;
    start[k]    = 1'b1;
    @(posedge clk);
    #1 start[k] = 1'b0;
  endtask

  task automatic send_byte(input int k, input logic [7:0] b, input bit gaps);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      in_valid[k] = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_byte[k]  = in_valid[k] ? b : 8'($urandom);
      if (in_valid[k] && m_rdy(k)) return;
    end
    check("send_timeout", k, 0, 1);
  endtask

  task automatic send_word(input int k, input logic [31:0] w, input bit gaps);
    for (int i = 3; i >= 0; i--) send_byte(k, w[8*i +: 8], gaps);
  endtask

  task automatic wait_done(input int k);
    @(negedge clk);
    in_valid[k] = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (done[k]) return;
      @(negedge clk);
    end
    check("done_timeout", k, 0, 1);
  endtask

  task automatic check_prog_log(input string tag, input logic [31:0] exp_w[6]);
    check({tag, "_writes"}, 0, 32'(log_d0.size()), 6);
    if (log_d0.size() == 6)
      for (int i = 0; i < 6; i++) begin
        check({tag, "_log_a"}, 0, 32'(log_a0[i]), 32'(i));
        check({tag, "_log_d"}, 0, log_d0[i], exp_w[i]);
      end
    check({tag, "_done"}, 0, 32'(done[0]), 1);
    check({tag, "_full"}, 0, 32'(full[0]), 0);
    check({tag, "_word_count"}, 0, get_wc(0), 6);
    check({tag, "_cpu_rst"}, 0, 32'(cpu_rst[0]), 0);
  endtask

  logic [31:0] prog[6] = '{32'h2001000B, 32'h2022001E, 32'h00220018,
                           32'h00221820, 32'hAC030004, 32'hFC000000};
  logic [31:0] words[4];
  logic [31:0] w;

  initial begin
    for (int k = 0; k < 2; k++) begin start[k] = 0; in_valid[k] = 0; in_byte[k] = 0; end
    repeat (3) @(negedge clk);
    check_reset(0, "init");
    rst = 1'b0;

    // Continuous stream: six writes, five cycles apart, terminated by FINISH.
    pulse_start(0);
    check("in_ready_after_start", 0, 32'(rdy[0]), 1);
    for (int i = 0; i < 6; i++) send_word(0, prog[i], 1'b0);
    wait_done(0);
    check_prog_log("cont", prog);
    if (log_c0.size() == 6) check("throughput_cycles", 0, 32'(log_c0[5] - log_c0[0]), 25);

    // Same program with random gaps in in_valid, started from DONE.
    log_a0.delete(); log_d0.delete(); log_c0.delete();
    pulse_start(0);
    for (int i = 0; i < 6; i++) send_word(0, prog[i], 1'b1);
    wait_done(0);
    check_prog_log("gaps", prog);

    // Four-deep instance fills up without a FINISH word.
    pulse_start(1);
    for (int i = 0; i < 4; i++) begin
      words[i] = $urandom & 32'h7FFF_FFFF;
      send_word(1, words[i], 1'b1);
    end
    wait_done(1);
    check("full_done", 1, 32'(done[1]), 1);
    check("full_full", 1, 32'(full[1]), 1);
    check("full_word_count", 1, get_wc(1), 4);
    check("full_writes", 1, 32'(log_d1.size()), 4);
    if (log_d1.size() == 4)
      for (int i = 0; i < 4; i++) begin
        check("full_log_a", 1, 32'(log_a1[i]), 32'(i));
        check("full_log_d", 1, log_d1[i], words[i]);
      end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid[1] = 1'b1;
      in_byte[1]  = 8'($urandom);
    end
    @(negedge clk);
    in_valid[1] = 1'b0;
    check("full_ignored_in_ready", 1, 32'(rdy[1]), 0);
    check("full_ignored_writes", 1, 32'(log_d1.size()), 4);

    // Asynchronous reset two bytes into the third word.
    log_a0.delete(); log_d0.delete();
    pulse_start(0);
    for (int i = 0; i < 2; i++) send_word(0, $urandom & 32'h7FFF_FFFF, 1'b0);
    w = 32'h1234_5678;
    send_byte(0, w[31:24], 1'b0);
    send_byte(0, w[23:16], 1'b0);
    @(negedge clk);
    in_valid[0] = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset(0, "async");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("async_writes", 0, 32'(log_d0.size()), 2);

    // New session; start pulses during WRITE and mid-word are ignored.
    log_a0.delete(); log_d0.delete();
    pulse_start(0);
    words[0] = $urandom & 32'h7FFF_FFFF;
    words[1] = $urandom & 32'h7FFF_FFFF;
    send_word(0, words[0], 1'b0);
    pulse_start(0);
    send_byte(0, words[1][31:24], 1'b0);
    pulse_start(0);
    for (int i = 2; i >= 0; i--) send_byte(0, words[1][8*i +: 8], 1'b0);
    send_word(0, 32'hFC00_0000, 1'b1);
    wait_done(0);
    check("restart_writes", 0, 32'(log_d0.size()), 3);
    if (log_d0.size() == 3) begin
      check("restart_first_a", 0, 32'(log_a0[0]), 0);
      check("restart_first_d", 0, log_d0[0], words[0]);
      check("restart_second_a", 0, 32'(log_a0[1]), 1);
      check("restart_second_d", 0, log_d0[1], words[1]);
      check("restart_third_a", 0, 32'(log_a0[2]), 2);
    end
    check("restart_word_count", 0, get_wc(0), 3);

    // Start from DONE, then a lone FINISH word.
    log_a0.delete(); log_d0.delete();
    pulse_start(0);
    check("redo_cpu_rst", 0, 32'(cpu_rst[0]), 1);
    check("redo_word_count", 0, get_wc(0), 0);
    check("redo_done", 0, 32'(done[0]), 0);
    send_word(0, 32'hFC00_0000, 1'b0);
    wait_done(0);
    check("redo_final_count", 0, get_wc(0), 1);
    check("redo_final_done", 0, 32'(done[0]), 1);
    check("redo_final_full", 0, 32'(full[0]), 0);
    check("redo_writes", 0, 32'(log_d0.size()), 1);
    if (log_d0.size() == 1) check("redo_a", 0, 32'(log_a0[0]), 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time writer for the instruction memory's write port (`a`, `d`, `we`). It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instructions. It writes each instruction to consecutive word addresses starting at 0 and holds the processor in reset until loading terminates. Loading ends on the FINISH instruction (opcode 111111) or when memory is full.

## Interface
- `ADDR_W`, 10, word-address width of the instruction memory write port.
- `DEPTH`, 1024, number of instruction words; the last writable address is DEPTH-1.
- `FINISH_OP`, 6'b111111, opcode (bits 31:26) that terminates loading.

- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a load session.
- `in_valid`  in  1  `in_byte` is valid this cycle.
- `in_byte`  in  8  instruction byte; the first byte of a word is bits 31:24.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `we`  out  1  instruction memory write enable (one-cycle pulse per word).
- `a`  out  ADDR_W  instruction memory word address; this is a word index, not a byte address.
- `d`  out  32  instruction memory write data.
- `busy`  out  1  a load session is in progress.
- `done`  out  1  the session terminated; level, held until the next `start` or reset.
- `full`  out  1  the session terminated by reaching DEPTH words rather than by FINISH.
- `cpu_rst`  out  1  processor reset request; high while not `done`.
- `word_count`  out  ADDR_W+1  number of words written in the current or last session.

## Operation
- State machine: IDLE, RECV, WRITE, DONE.
- Reset values:
  - State is IDLE; the byte counter and the address counter are 0.
  - `in_ready`, `we`, `busy`, `done` and `full` are 0.
  - `cpu_rst` is 1.
  - `a`, `d` and `word_count` are 0.
- IDLE:
  - `start` moves to RECV.
  - Bytes are not accepted (`in_ready`=0).
  - `cpu_rst` is 1.
- RECV:
  - `in_ready`=1 and `busy`=1.
  - Each handshake (`in_valid` & `in_ready` at a rising edge) shifts `in_byte` into the word register MSB-first and increments the byte counter (0-3).
  - On the 4th byte, move to WRITE and reset the byte counter to 0.
  - Gaps in `in_valid` stall collection with no timeout.
- WRITE:
  - Lasts exactly one cycle with `we`=1, `a`=current address and `d`=the assembled word.
  - `in_ready`=0.
  - `word_count` increments at the end of this cycle.
- After WRITE:
  - If d[31:26]==FINISH_OP, go to DONE with `full`=0. The FINISH word itself is written.
  - Otherwise, if the address equals DEPTH-1, go to DONE with `full`=1.
  - Otherwise, increment the address and return to RECV.
- DONE:
  - `done`=1, `busy`=0, `cpu_rst`=0 and `in_ready`=0.
  - `a` and `d` hold their last written values.
  - `start` clears `done`, `full`, `word_count`, the address and the byte counter, asserts `cpu_rst`, and moves to RECV.
- `start` in RECV or WRITE is ignored; the session is not restarted.
- Address arithmetic: the address counter is ADDR_W bits and never wraps. Termination at DEPTH-1 precedes any increment.
- `word_count` reaches at most DEPTH.
- Outside WRITE, `we` is 0.

## Timing
- `in_ready` rises in the first cycle after the `start` edge.
- Minimum of 5 cycles per word: 4 byte-accept cycles plus 1 WRITE cycle. Throughput is 1 word per 5 cycles under continuous `in_valid`.
- `we`, `a` and `d` are registered. They appear in the cycle after the 4th byte handshake, and the memory captures them on the following edge.
- `done` and the `cpu_rst` deassertion occur in the cycle immediately after the terminating WRITE cycle.
- Asserting `rst` mid-word or mid-WRITE immediately (asynchronously):
  - forces all outputs to their reset values;
  - sets `we` to 0;
  - discards the partial word.

  After `rst` releases, the loader waits for a new `start`.

## Test plan
- Stream 5 words (0x2001000B, 0x2022001E, 0x00220018, 0x00221820, 0xAC030004) then 0xFC000000, with `in_valid` held high:
  - 6 `we` pulses at `a`=0..5 with matching `d`;
  - `done`=1, `full`=0, `word_count`=6;
  - `cpu_rst` falls the cycle after the 6th write.
- Same stream with `in_valid` toggled randomly (50% duty) -> identical writes and values; `we` pulses only after each 4th accepted byte.
- With DEPTH=4, stream 4 non-FINISH words -> writes at `a`=0..3, then `done`=1, `full`=1, `word_count`=4; `in_ready` is 0 afterwards and further bytes are ignored.
- Assert `rst` after 2 bytes of word 3:
  - all outputs return to reset values immediately and no `we` occurs;
  - after a new `start`, the first word is written at `a`=0.
- Pulse `start` mid-session -> ignored, and the address sequence continues unbroken.
- Pulse `start` in DONE, then stream 0xFC000000 -> `cpu_rst` goes to 1 and `word_count` clears to 0; one write occurs at `a`=0, then `done`=1 with `word_count`=1.
